shiftreg_serializer: RTL

Parallel-to-serial transmitter that produces the serial bit stream and per-bit write strobe consumed by the parametric serial shift-register delay line. It accepts one WIDTH-bit word through a valid/ready handshake and emits its bits one per enabled cycle. Supports downstream stall, clock-gate qualification and back-to-back words with no bubble. Sits between word-oriented Bluespec logic and serial shift-register chains.

---
 rtl/shiftreg_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/shiftreg_serializer.sv
// ---------------------------------------------------------------------------
// shiftreg_serializer
//
// Parallel-to-serial transmitter feeding a serial shift-register delay line.
// A WIDTH-bit word is taken in through a valid/ready handshake and its bits
// are emitted one per enabled cycle, together with a per-bit write strobe.
// Downstream stall holds the current bit, CLK_GATE freezes everything, and
// a new word can be accepted on the last bit of the current one so that
// back-to-back words stream with no idle cycle in between.
//
// Parameters:
//   WIDTH      word width in bits (2..1024)
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports:
//   CLK           in   clock, rising edge
//   RST           in   asynchronous active-high reset
//   CLK_GATE      in   0 freezes all state, strobes and handshakes
//   inData        in   parallel word to transmit (sampled only on accept)
//   inValid       in   inData is valid
//   inReady       out  block accepts inData this cycle
//   serialData    out  current serial bit (delay line writeData)
//   serialEnable  out  bit-valid strobe (delay line writeEnable)
//   serialStall   in   downstream backpressure, holds the current bit
//   busy          out  a word is loaded and not yet fully emitted
//   wordDone      out  registered one-cycle pulse after the last bit
// ---------------------------------------------------------------------------
module shiftreg_serializer #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLK_GATE,
   input  logic [WIDTH-1:0] inData,
   input  logic             inValid,
   output logic             inReady,
   output logic             serialData,
   output logic             serialEnable,
   input  logic             serialStall,
   output logic             busy,
   output logic             wordDone
);

   // The counter holds "bits remaining minus one", so it only ever needs to
   // reach WIDTH-1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sr;
   logic [CW-1:0]    r_count;
   logic             r_wordDone;

   logic             w_bitGo;
   logic             w_lastBit;
   logic             w_fire;
   logic             w_headBit;
   logic [WIDTH-1:0] w_shifted;

   // The emitted end of the shift register and the value it takes after one
   // bit has been consumed depend on bit order; zeros fill the vacated end,
   // so after the last bit the register is already all-zero.
   generate
      if (MSB_FIRST) begin : g_msbFirst
         assign w_headBit = r_sr[WIDTH-1];
         assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
      end else begin : g_lsbFirst
         assign w_headBit = r_sr[0];
         assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
      end
   endgenerate

   // A bit leaves only while shifting, with the gate open and no stall.
   // The last bit of a word is the one where the counter has reached zero;
   // that is also the only moment the block can take the next word while
   // still busy, which is what gives gap-free back-to-back streaming.
   assign w_bitGo      = (r_state == SHIFT) & CLK_GATE & ~serialStall;
   assign w_lastBit    = w_bitGo & (r_count == '0);
   assign inReady      = CLK_GATE & ~RST & ((r_state == IDLE) | w_lastBit);
   assign w_fire       = inValid & inReady;
   assign serialEnable = w_bitGo;
   assign serialData   = (r_state == SHIFT) ? w_headBit : 1'b0;
   assign busy         = (r_state == SHIFT);
   assign wordDone     = r_wordDone;

   // Main control: a closed gate freezes every register, including the
   // wordDone pulse, so a pulse produced right before the gate closes stays
   // visible until the next gated edge. A stalled bit simply holds sr and
   // count. On the last bit either the next word is loaded in place or the
   // block drops back to IDLE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= IDLE;
         r_sr       <= '0;
         r_count    <= '0;
         r_wordDone <= 1'b0;
      end else if (CLK_GATE) begin
         r_wordDone <= w_lastBit;
         case (r_state)
            IDLE: begin
               if (w_fire) begin
                  r_sr    <= inData;
                  r_count <= LAST_COUNT;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_bitGo) begin
                  if (r_count != '0) begin
                     r_sr    <= w_shifted;
                     r_count <= r_count - CW'(1);
                  end else if (w_fire) begin
                     r_sr    <= inData;
                     r_count <= LAST_COUNT;
                  end else begin
                     r_sr    <= w_shifted;
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
